// File: rtl/timer_bridge_if.sv
// CPU data-side bus shared by the MEM stage, the timer bridge and data memory.
// The master side plays both the CPU and the data memory read port.
interface timer_bridge_if #(
  parameter int NUM_TC = 2
);
  logic [31:0]       addr;
  logic [3:0]        cpu_byte_en;
  logic [31:0]       wdata;
  logic [31:0]       dm_rdata;
  logic [31:0]       dm_addr;
  logic [3:0]        dm_byte_en;
  logic [31:0]       rdata;
  logic [NUM_TC-1:0] hw_int;
  logic              addr_err;

  modport master (
    output addr, cpu_byte_en, wdata, dm_rdata,
    input  dm_addr, dm_byte_en, rdata, hw_int, addr_err
  );

  modport slave (
    input  addr, cpu_byte_en, wdata, dm_rdata,
    output dm_addr, dm_byte_en, rdata, hw_int, addr_err
  );
endinterface

// File: rtl/timer_bridge.sv
// System bridge: splits CPU data accesses between data memory and NUM_TC
// memory-mapped countdown timers, and drives the hardware-interrupt vector.
module timer_bridge #(
  parameter int          NUM_TC    = 2,
  parameter logic [31:0] DM_LIMIT  = 32'h0000_3000,
  parameter logic [31:0] TC_BASE   = 32'h0000_7F00,
  parameter logic [31:0] TC_STRIDE = 32'h10
) (
  input logic           clk,
  input logic           reset,
  timer_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} tcState_e;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  logic [NUM_TC-1:0] en_q, en_d;
  logic [NUM_TC-1:0] im_q, im_d;
  logic [NUM_TC-1:0] pend_q, pend_d;
  logic [1:0]        mode_q   [NUM_TC];
  logic [1:0]        mode_d   [NUM_TC];
  logic [31:0]       preset_q [NUM_TC];
  logic [31:0]       preset_d [NUM_TC];
  logic [31:0]       count_q  [NUM_TC];
  logic [31:0]       count_d  [NUM_TC];
  tcState_e          state_q  [NUM_TC];
  tcState_e          state_d  [NUM_TC];

  logic              dmHit;
  logic              tcAnyHit;
  logic              fullStore;
  logic [1:0]        regOff;
  logic [31:0]       chanBase;
  logic [31:0]       tcRdata;
  logic [NUM_TC-1:0] tcHit;
  logic [NUM_TC-1:0] ctrlWr;
  logic [NUM_TC-1:0] presetWr;

  // Address decode; data memory takes priority should the windows ever overlap.
  always_comb begin
    dmHit     = (bus.addr < DM_LIMIT);
    regOff    = bus.addr[3:2];
    fullStore = (bus.cpu_byte_en == 4'hF);
    chanBase  = '0;
    tcHit     = '0;
    ctrlWr    = '0;
    presetWr  = '0;
    tcRdata   = '0;
    for (int k = 0; k < NUM_TC; k++) begin
      chanBase = TC_BASE + TC_STRIDE * 32'(k);
      if (!dmHit && ((bus.addr - chanBase) < 32'hC) && (regOff != 2'd3)) begin
        tcHit[k]    = 1'b1;
        ctrlWr[k]   = fullStore && (regOff == 2'd0);
        presetWr[k] = fullStore && (regOff == 2'd1);
        case (regOff)
          2'd0:    tcRdata = {27'd0, pend_q[k], im_q[k], mode_q[k], en_q[k]};
          2'd1:    tcRdata = preset_q[k];
          default: tcRdata = count_q[k];
        endcase
      end
    end
  end

  assign tcAnyHit       = |tcHit;
  assign bus.dm_addr    = dmHit ? bus.addr : '0;
  assign bus.dm_byte_en = dmHit ? bus.cpu_byte_en : '0;
  assign bus.rdata      = dmHit ? bus.dm_rdata : tcRdata;
  assign bus.addr_err   = !(dmHit || tcAnyHit) ||
                          (tcAnyHit && (bus.cpu_byte_en != 4'h0) && !fullStore);
  assign bus.hw_int     = pend_q & im_q;

  // PEND is raised on the edge that enters INT so expiry lands PRESET+2 edges
  // after enabling; a CPU CTRL store overrides any FSM update of EN/MODE/IM.
  always_comb begin
    en_d   = en_q;
    im_d   = im_q;
    pend_d = pend_q;
    for (int k = 0; k < NUM_TC; k++) begin
      mode_d[k]   = mode_q[k];
      preset_d[k] = presetWr[k] ? bus.wdata : preset_q[k];
      count_d[k]  = count_q[k];
      state_d[k]  = state_q[k];

      if (mode_q[k] == MODE_RELOAD || ctrlWr[k]) begin
        pend_d[k] = 1'b0;
      end

      unique case (state_q[k])
        IDLE: begin
          if (en_q[k]) begin
            state_d[k] = LOAD;
          end
        end
        LOAD: begin
          count_d[k] = preset_q[k];
          state_d[k] = CNT;
        end
        CNT: begin
          if (!en_q[k]) begin
            state_d[k] = IDLE;
          end else if (count_q[k] <= 32'd1) begin
            count_d[k] = '0;
            pend_d[k]  = 1'b1;
            state_d[k] = INT;
          end else begin
            count_d[k] = count_q[k] - 32'd1;
          end
        end
        INT: begin
          if (mode_q[k] == MODE_RELOAD) begin
            state_d[k] = LOAD;
          end else begin
            en_d[k]    = 1'b0;
            state_d[k] = IDLE;
          end
        end
      endcase

      if (ctrlWr[k]) begin
        en_d[k]   = bus.wdata[0];
        mode_d[k] = bus.wdata[2:1];
        im_d[k]   = bus.wdata[3];
        if (state_q[k] == INT && !bus.wdata[0]) begin
          state_d[k] = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q   <= '0;
      im_q   <= '0;
      pend_q <= '0;
      for (int k = 0; k < NUM_TC; k++) begin
        mode_q[k]   <= '0;
        preset_q[k] <= '0;
        count_q[k]  <= '0;
        state_q[k]  <= IDLE;
      end
    end else begin
      en_q   <= en_d;
      im_q   <= im_d;
      pend_q <= pend_d;
      for (int k = 0; k < NUM_TC; k++) begin
        mode_q[k]   <= mode_d[k];
        preset_q[k] <= preset_d[k];
        count_q[k]  <= count_d[k];
        state_q[k]  <= state_d[k];
      end
    end
  end

endmodule
